slv_guard_recovery_ctrl: RTL

// - Sequences recovery of a guarded AXI subordinate after the slave guard raises a reset request.
// - Enables the guard, isolates the subordinate, drives its reset, waits for ready, then acknowledges the guard.
// - Sits between slv_guard_top (rst_req_o/irq_o/rst_stat_i) and the subordinate's reset/isolation logic.

---
 rtl/slv_guard_recovery_pkg.sv | 28 ++
 rtl/slv_guard_recovery_if.sv | 36 +++
 rtl/slv_guard_recovery_tmr.sv | 28 ++
 rtl/slv_guard_recovery_ctrl.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/slv_guard_recovery_pkg.sv
// Shared types and constants for the slave-guard recovery controller.
package slv_guard_recovery_pkg;

   localparam int unsigned RecovCntWidth = 16;

   typedef logic [RecovCntWidth-1:0] recov_cnt_t;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      ISOLATE  = 3'd1,
      RESET    = 3'd2,
      WAIT_RDY = 3'd3,
      SETTLE   = 3'd4,
      FATAL    = 3'd5
   } recov_state_e;

   // Timer width wide enough to hold the largest per-state cycle count.
   function automatic int unsigned tmr_width(input int unsigned a, input int unsigned b,
                                             input int unsigned c, input int unsigned d);
      int unsigned m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      if (d > m) m = d;
      return $clog2(m + 1);
   endfunction

endpackage

// File: rtl/slv_guard_recovery_if.sv
// Guard / subordinate control bundle seen by the recovery controller.
interface slv_guard_recovery_if #(
   parameter int unsigned MaxRetries = 3
);
   import slv_guard_recovery_pkg::*;

   localparam int unsigned RetryCntWidth = $clog2(MaxRetries + 1);

   logic                     ctrl_en_i;
   logic                     rst_req_i;
   logic                     irq_i;
   logic                     guard_ena_o;
   logic                     isolate_o;
   logic                     isolated_i;
   logic                     sub_rst_no;
   logic                     sub_rdy_i;
   logic                     rst_stat_o;
   logic                     busy_o;
   logic                     fatal_o;
   logic                     fatal_clr_i;
   logic [RetryCntWidth-1:0] retry_cnt_o;
   recov_cnt_t               recov_cnt_o;

   modport master (
      input  ctrl_en_i, rst_req_i, irq_i, isolated_i, sub_rdy_i, fatal_clr_i,
      output guard_ena_o, isolate_o, sub_rst_no, rst_stat_o, busy_o, fatal_o,
             retry_cnt_o, recov_cnt_o
   );

   modport slave (
      output ctrl_en_i, rst_req_i, irq_i, isolated_i, sub_rdy_i, fatal_clr_i,
      input  guard_ena_o, isolate_o, sub_rst_no, rst_stat_o, busy_o, fatal_o,
             retry_cnt_o, recov_cnt_o
   );

endinterface

// File: rtl/slv_guard_recovery_tmr.sv
// Loadable down-counter; expired_o is registered and high while the count sits at zero.
module slv_guard_recovery_tmr #(
   parameter int unsigned Width = 9
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             load_i,
   input  logic [Width-1:0] val_i,
   output logic             expired_o
);

   logic [Width-1:0] cnt_q;

   // Holds at zero once reached; no wrap.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q     <= '0;
         expired_o <= 1'b1;
      end else if (load_i) begin
         cnt_q     <= val_i;
         expired_o <= (val_i == '0);
      end else if (cnt_q != '0) begin
         cnt_q     <= cnt_q - Width'(1);
         expired_o <= (cnt_q == Width'(1));
      end
   end

endmodule

// File: rtl/slv_guard_recovery_ctrl.sv
// Recovery sequencer for a guarded subordinate: isolate, reset, wait ready, acknowledge guard.
// Optional completed-recovery counter enabled by SLV_GUARD_RECOVERY_STATS_EN.
module slv_guard_recovery_ctrl #(
   parameter int unsigned IsoTimeout    = 64,
   parameter int unsigned RstHoldCycles = 16,
   parameter int unsigned RdyTimeout    = 256,
   parameter int unsigned SettleCycles  = 4,
   parameter int unsigned MaxRetries    = 3,
   parameter int unsigned TmrWidth      = slv_guard_recovery_pkg::tmr_width(
                                             IsoTimeout, RstHoldCycles, RdyTimeout, SettleCycles)
) (
   input logic                  clk_i,
   input logic                  rst_ni,
   slv_guard_recovery_if.master bus
);
   import slv_guard_recovery_pkg::*;

   localparam int unsigned RetryCntWidth = $clog2(MaxRetries + 1);

   recov_state_e             state_q, state_d;
   logic [RetryCntWidth-1:0] retry_q, retry_d;
   logic                     guard_ena_q, guard_ena_d;
   logic                     isolate_q, isolate_d;
   logic                     sub_rst_n_q, sub_rst_n_d;
   logic                     rst_stat_q, rst_stat_d;
   logic                     busy_q, busy_d;
   logic                     fatal_q, fatal_d;
   logic                     tmr_load, tmr_expired;
   logic [TmrWidth-1:0]      tmr_val;
   logic                     trigger;

   assign trigger = bus.rst_req_i | bus.irq_i;

   // Next state, timer reload and next registered outputs.
   always_comb begin
      state_d     = state_q;
      retry_d     = retry_q;
      tmr_val     = '0;
      guard_ena_d = 1'b0;
      isolate_d   = 1'b1;
      sub_rst_n_d = 1'b1;
      busy_d      = 1'b1;
      fatal_d     = 1'b0;

      case (state_q)
         IDLE:     if (trigger && bus.ctrl_en_i) state_d = ISOLATE;
         ISOLATE:  if (bus.isolated_i || tmr_expired) state_d = RESET;
         RESET:    if (tmr_expired) state_d = WAIT_RDY;
         WAIT_RDY: begin
            if (bus.sub_rdy_i) begin
               state_d = SETTLE;
            end else if (tmr_expired) begin
               retry_d = retry_q + RetryCntWidth'(1);
               state_d = (retry_q == RetryCntWidth'(MaxRetries - 1)) ? FATAL : RESET;
            end
         end
         SETTLE: begin
            if (tmr_expired) begin
               state_d = IDLE;
               retry_d = '0;
            end
         end
         FATAL: begin
            if (bus.fatal_clr_i) begin
               state_d = IDLE;
               retry_d = '0;
            end
         end
         default:  state_d = IDLE;
      endcase

      // Timer counts N-1 down to zero so each state lasts exactly N cycles.
      tmr_load = (state_d != state_q);
      case (state_d)
         ISOLATE:  tmr_val = TmrWidth'(IsoTimeout - 1);
         RESET:    tmr_val = TmrWidth'(RstHoldCycles - 1);
         WAIT_RDY: tmr_val = TmrWidth'(RdyTimeout - 1);
         SETTLE:   tmr_val = TmrWidth'(SettleCycles - 1);
         default:  tmr_val = '0;
      endcase

      case (state_d)
         IDLE: begin
            guard_ena_d = bus.ctrl_en_i;
            isolate_d   = 1'b0;
            busy_d      = 1'b0;
         end
         RESET:   sub_rst_n_d = 1'b0;
         FATAL: begin
            sub_rst_n_d = 1'b0;
            fatal_d     = 1'b1;
         end
         default: ;
      endcase

      rst_stat_d = (state_q == SETTLE) && (state_d == IDLE);
   end

   // State and output registers.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= IDLE;
         retry_q     <= '0;
         guard_ena_q <= 1'b0;
         isolate_q   <= 1'b0;
         sub_rst_n_q <= 1'b1;
         rst_stat_q  <= 1'b0;
         busy_q      <= 1'b0;
         fatal_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         retry_q     <= retry_d;
         guard_ena_q <= guard_ena_d;
         isolate_q   <= isolate_d;
         sub_rst_n_q <= sub_rst_n_d;
         rst_stat_q  <= rst_stat_d;
         busy_q      <= busy_d;
         fatal_q     <= fatal_d;
      end
   end

   slv_guard_recovery_tmr #(
      .Width (TmrWidth)
   ) u_tmr (
      .clk_i     (clk_i),
      .rst_ni    (rst_ni),
      .load_i    (tmr_load),
      .val_i     (tmr_val),
      .expired_o (tmr_expired)
   );

`ifdef SLV_GUARD_RECOVERY_STATS_EN
   recov_cnt_t recov_cnt_q;

   // Saturating count of completed recoveries, aligned with the rst_stat_o pulse.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         recov_cnt_q <= '0;
      end else if (rst_stat_d && (recov_cnt_q != '1)) begin
         recov_cnt_q <= recov_cnt_q + RecovCntWidth'(1);
      end
   end

   assign bus.recov_cnt_o = recov_cnt_q;
`else
   assign bus.recov_cnt_o = '0;
`endif

   assign bus.guard_ena_o = guard_ena_q;
   assign bus.isolate_o   = isolate_q;
   assign bus.sub_rst_no  = sub_rst_n_q;
   assign bus.rst_stat_o  = rst_stat_q;
   assign bus.busy_o      = busy_q;
   assign bus.fatal_o     = fatal_q;
   assign bus.retry_cnt_o = retry_q;

endmodule
